// File: rtl/sync_fifo_gen2_if.sv
// Producer/consumer bundle for sync_fifo_gen2: write/read requests, flush, read data and status flags.
// The master modport drives requests; the slave modport is the FIFO side.
interface sync_fifo_gen2_if #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 8
);
  logic                         clr;
  logic                         wr;
  logic [DATA_WIDTH-1:0]        data;
  logic                         rd;
  logic [DATA_WIDTH-1:0]        q;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         mty;
  logic                         almost_mty;
  logic                         full;
  logic                         almost_full;
  logic                         overflow;
  logic                         underflow;

  modport master (
    output clr, wr, data, rd,
    input  q, count, mty, almost_mty, full, almost_full, overflow, underflow
  );

  modport slave (
    input  clr, wr, data, rd,
    output q, count, mty, almost_mty, full, almost_full, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_gen2.sv
// Single-clock FIFO, any DEPTH>=2; q one cycle after rd (or show-ahead), flags registered from next count.
// Backpressure: wr dropped while full, rd ignored while empty; sticky error flags under FIFO_ERR_FLAGS_EN.
module sync_fifo_gen2 #(
  parameter int DATA_WIDTH  = 128,
  parameter int DEPTH       = 8,
  parameter int ALMOST_MTY  = 1,
  parameter int ALMOST_FULL = 1,
  parameter int SHOW_AHEAD  = 0
) (
  input logic              CLK,
  input logic              ARST,
  sync_fifo_gen2_if.slave  bus
);
  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic AMTY_RST  = (ALMOST_MTY >= 0);
  localparam logic AFULL_RST = (ALMOST_FULL >= DEPTH);

  if (DEPTH < 2 || ALMOST_MTY < 0 || ALMOST_MTY > DEPTH - 1 ||
      ALMOST_FULL < 0 || ALMOST_FULL > DEPTH - 1) begin : gBadParam
    $fatal(1, "sync_fifo_gen2: illegal DEPTH or almost threshold");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wrPtr;
  logic [PW-1:0]         rdPtr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         countNext;
  logic                  mty;
  logic                  full;
  logic                  almostMty;
  logic                  almostFull;
  logic                  wrAcc;
  logic                  rdAcc;

  assign wrAcc     = bus.wr & ~full & ~bus.clr;
  assign rdAcc     = bus.rd & ~mty & ~bus.clr;
  assign countNext = count + CW'(wrAcc) - CW'(rdAcc);

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      mty        <= 1'b1;
      full       <= 1'b0;
      almostMty  <= AMTY_RST;
      almostFull <= AFULL_RST;
    end else if (bus.clr) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      mty        <= 1'b1;
      full       <= 1'b0;
      almostMty  <= AMTY_RST;
      almostFull <= AFULL_RST;
    end else begin
      if (wrAcc) wrPtr <= ptrInc(wrPtr);
      if (rdAcc) rdPtr <= ptrInc(rdPtr);
      count      <= countNext;
      mty        <= (countNext == '0);
      full       <= (countNext == CW'(DEPTH));
      almostMty  <= (countNext <= CW'(ALMOST_MTY));
      almostFull <= (countNext >= CW'(DEPTH - ALMOST_FULL));
    end
  end

  always_ff @(posedge CLK) begin
    if (wrAcc) mem[wrPtr] <= bus.data;
  end

  if (SHOW_AHEAD == 0) begin : gRegQ
    logic [DATA_WIDTH-1:0] qReg;
    // Holds its value across clr: only an accepted read reloads it.
    always_ff @(posedge CLK or posedge ARST) begin
      if (ARST)       qReg <= '0;
      else if (rdAcc) qReg <= mem[rdPtr];
    end
    assign bus.q = qReg;
  end else begin : gFwftQ
    assign bus.q = mty ? '0 : mem[rdPtr];
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflowR;
  logic underflowR;
  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      overflowR  <= 1'b0;
      underflowR <= 1'b0;
    end else if (bus.clr) begin
      overflowR  <= 1'b0;
      underflowR <= 1'b0;
    end else begin
      if (bus.wr && full) overflowR  <= 1'b1;
      if (bus.rd && mty)  underflowR <= 1'b1;
    end
  end
  assign bus.overflow  = overflowR;
  assign bus.underflow = underflowR;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

  assign bus.count       = count;
  assign bus.mty         = mty;
  assign bus.full        = full;
  assign bus.almost_mty  = almostMty;
  assign bus.almost_full = almostFull;
endmodule

// File: tb/tb_sync_fifo_gen2.sv
// Bench for sync_fifo_gen2: registered-read and show-ahead instances share stimulus and a queue-based model.
module tb_sync_fifo_gen2;
  localparam int DW    = 8;
  localparam int DEPTH = 5;

  logic          CLK = 1'b0;
  logic          ARST;
  logic          wr, rd, clr;
  logic [DW-1:0] data;

  always #5 CLK = ~CLK;

  sync_fifo_gen2_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus0 ();
  sync_fifo_gen2_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus1 ();

  assign bus0.wr = wr;  assign bus0.rd = rd;  assign bus0.clr = clr;  assign bus0.data = data;
  assign bus1.wr = wr;  assign bus1.rd = rd;  assign bus1.clr = clr;  assign bus1.data = data;

  sync_fifo_gen2 #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_MTY(1), .ALMOST_FULL(1), .SHOW_AHEAD(0))
    u_dut0 (.CLK(CLK), .ARST(ARST), .bus(bus0));
  sync_fifo_gen2 #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_MTY(1), .ALMOST_FULL(1), .SHOW_AHEAD(1))
    u_dut1 (.CLK(CLK), .ARST(ARST), .bus(bus1));

  int nChecks = 0;
  int nErr    = 0;

  // Reference model: contents as a queue, last popped word, sticky errors.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] mQ0;
  bit            mOvf, mUnf;

  typedef struct {
    bit            w;
    logic [DW-1:0] d;
    bit            r;
    bit            c;
    int            eCnt;
    bit            eMty;
    bit            eAmty;
    bit            eFull;
    bit            eAfull;
    logic [DW-1:0] eQ;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mQ0  = '0;
    mOvf = 1'b0;
    mUnf = 1'b0;
  endtask

  task automatic modelStep();
    bit isFull;
    bit isEmpty;
    if (clr) begin
      mq.delete();
      mOvf = 1'b0;
      mUnf = 1'b0;
    end else begin
      isFull  = (mq.size() == DEPTH);
      isEmpty = (mq.size() == 0);
`ifdef FIFO_ERR_FLAGS_EN
      if (wr && isFull)  mOvf = 1'b1;
      if (rd && isEmpty) mUnf = 1'b1;
`endif
      if (rd && !isEmpty) mQ0 = mq.pop_front();
      if (wr && !isFull)  mq.push_back(data);
    end
  endtask

  task automatic checkAll();
    int n;
    int q1;
    n  = mq.size();
    q1 = (n == 0) ? 0 : int'(mq[0]);
    chk("dut0.count",       bus0.count,       n);
    chk("dut0.mty",         bus0.mty,         int'(n == 0));
    chk("dut0.almost_mty",  bus0.almost_mty,  int'(n <= 1));
    chk("dut0.full",        bus0.full,        int'(n == DEPTH));
    chk("dut0.almost_full", bus0.almost_full, int'(n >= DEPTH - 1));
    chk("dut0.overflow",    bus0.overflow,    int'(mOvf));
    chk("dut0.underflow",   bus0.underflow,   int'(mUnf));
    chk("dut0.q",           bus0.q,           int'(mQ0));
    chk("dut1.count",       bus1.count,       n);
    chk("dut1.mty",         bus1.mty,         int'(n == 0));
    chk("dut1.full",        bus1.full,        int'(n == DEPTH));
    chk("dut1.overflow",    bus1.overflow,    int'(mOvf));
    chk("dut1.underflow",   bus1.underflow,   int'(mUnf));
    chk("dut1.q",           bus1.q,           q1);
  endtask

  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    wr = w; data = d; rd = r; clr = c;
    @(posedge CLK);
    modelStep();
    #1;
    checkAll();
  endtask

  task automatic doReset();
    ARST = 1'b1; wr = 1'b0; rd = 1'b0; clr = 1'b0; data = '0;
    modelReset();
    repeat (2) @(posedge CLK);
    #1 ARST = 1'b0;
  endtask

  logic [DW-1:0] expWrap[5];

  initial begin
    tbl[0] = '{1, 8'h11, 0, 0, 1, 0, 1, 0, 0, 8'h00};
    tbl[1] = '{1, 8'h12, 0, 0, 2, 0, 0, 0, 0, 8'h00};
    tbl[2] = '{1, 8'h13, 0, 0, 3, 0, 0, 0, 0, 8'h00};
    tbl[3] = '{1, 8'h14, 0, 0, 4, 0, 0, 0, 1, 8'h00};
    tbl[4] = '{1, 8'h15, 0, 0, 5, 0, 0, 1, 1, 8'h00};
    tbl[5] = '{1, 8'h16, 0, 0, 5, 0, 0, 1, 1, 8'h00};
    tbl[6] = '{0, 8'h00, 1, 0, 4, 0, 0, 0, 1, 8'h11};
    tbl[7] = '{1, 8'h17, 1, 0, 4, 0, 0, 0, 1, 8'h12};
    tbl[8] = '{1, 8'h18, 1, 1, 0, 1, 1, 0, 0, 8'h12};
    tbl[9] = '{0, 8'h00, 1, 0, 0, 1, 1, 0, 0, 8'h12};
    expWrap[0] = 8'h14; expWrap[1] = 8'h15; expWrap[2] = 8'hA1;
    expWrap[3] = 8'hA2; expWrap[4] = 8'hA3;

    // Reset and idle.
    doReset();
    cycle(0, 8'h00, 0, 0);
    chk("reset.almost_full", bus0.almost_full, 0);
    chk("reset.q0", bus0.q, 0);

    // Fill past full, drain, flush: explicit expectations per row.
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].c);
      chk("tbl.count",       bus0.count,       tbl[i].eCnt);
      chk("tbl.mty",         bus0.mty,         int'(tbl[i].eMty));
      chk("tbl.almost_mty",  bus0.almost_mty,  int'(tbl[i].eAmty));
      chk("tbl.full",        bus0.full,        int'(tbl[i].eFull));
      chk("tbl.almost_full", bus0.almost_full, int'(tbl[i].eAfull));
      chk("tbl.q",           bus0.q,           int'(tbl[i].eQ));
    end

    // Pointer wrap across the non-power-of-two boundary.
    doReset();
    for (int i = 0; i < 5; i++) cycle(1, 8'h11 + 8'(i), 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 8'hA1 + 8'(i), 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 8'h00, 1, 0);
      chk("wrap.q", bus0.q, int'(expWrap[i]));
    end
    chk("wrap.mty", bus0.mty, 1);

    // Simultaneous read and write at count 2, then at full.
    doReset();
    cycle(1, 8'hB0, 0, 0);
    cycle(1, 8'hB1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 8'hC0 + 8'(i), 1, 0);
      chk("rdwr.count", bus0.count, 2);
    end
    for (int i = 0; i < 3; i++) cycle(1, 8'hD0 + 8'(i), 0, 0);
    cycle(1, 8'hEE, 1, 0);
    chk("rdwr_full.count", bus0.count, 4);

    // Show-ahead: word visible as mty falls, popped by rd, then underflow.
    doReset();
    cycle(1, 8'h5A, 0, 0);
    chk("sa.q", bus1.q, 8'h5A);
    chk("sa.mty", bus1.mty, 0);
    cycle(0, 8'h00, 1, 0);
    chk("sa.q_after_pop", bus1.q, 0);
    chk("sa.mty_after_pop", bus1.mty, 1);
    cycle(0, 8'h00, 1, 0);

    // Flush with wr at count 3 while overflow is set.
    doReset();
    for (int i = 0; i < 6; i++) cycle(1, 8'h30 + 8'(i), 0, 0);
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 1, 0);
    cycle(1, 8'h77, 0, 1);
    chk("clr.count", bus0.count, 0);
    chk("clr.mty", bus0.mty, 1);
    chk("clr.overflow", bus0.overflow, 0);
    cycle(0, 8'h00, 0, 0);
    cycle(1, 8'h88, 0, 0);
    cycle(0, 8'h00, 1, 0);
    chk("clr.next_word", bus0.q, 8'h88);

    // Asynchronous reset between clock edges.
    for (int i = 0; i < 3; i++) cycle(1, 8'h40 + 8'(i), 0, 0);
    cycle(0, 8'h00, 1, 0);
    wr = 1'b1; rd = 1'b1; data = 8'h99;
    ARST = 1'b1;
    #2;
    modelReset();
    checkAll();
    chk("arst.q0", bus0.q, 0);
    #1 ARST = 1'b0;
    cycle(0, 8'h00, 0, 0);

    // Randomized traffic with phases biased towards full and towards empty.
    for (int i = 0; i < 3000; i++) begin
      int wPct;
      wPct = ((i / 250) % 2 == 0) ? 75 : 25;
      cycle($urandom_range(0, 99) < wPct, 8'($urandom),
            $urandom_range(0, 99) < (100 - wPct), $urandom_range(0, 63) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
    $finish;
  end
endmodule

// File: doc/sync_fifo_gen2.md
Name: sync_fifo_gen2

Overview:
- Second-generation single-clock FIFO for datapath buffering between pipeline stages.
- Generalises the first-generation FIFO:
  - any DEPTH ≥ 2, including non-power-of-two;
  - exact occupancy count;
  - flags that are correct in the same cycle as the pointer update;
  - selectable standard or show-ahead read mode;
  - synchronous flush.
- Sits between a producer issuing wr/data and a consumer issuing rd/q.

Parameters:
- DATA_WIDTH, 128, width of data and q.
- DEPTH, 8, number of entries; ≥ 2, need not be a power of two.
- ALMOST_MTY, 1, almost_mty asserted when count ≤ ALMOST_MTY; range 0..DEPTH-1.
- ALMOST_FULL, 1, almost_full asserted when count ≥ DEPTH-ALMOST_FULL; range 0..DEPTH-1.
- SHOW_AHEAD, 0, 0 = registered read data, 1 = first-word-fall-through.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- ARST  in  1  asynchronous reset, active-high.
- clr  in  1  synchronous flush.
- wr  in  1  write request.
- data  in  DATA_WIDTH  write data.
- rd  in  1  read request.
- q  out  DATA_WIDTH  read data.
- count  out  $clog2(DEPTH+1)  current occupancy.
- mty  out  1  empty.
- almost_mty  out  1  almost empty.
- full  out  1  full.
- almost_full  out  1  almost full.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- One clock, CLK; reset ARST is asynchronous and active-high.
- Reset values:
  - internal write and read pointers = 0;
  - count = 0, q = 0;
  - mty = 1, almost_mty = 1, full = 0;
  - almost_full = (ALMOST_FULL ≥ DEPTH) ? 1 : 0, which is 0 for all legal values;
  - overflow = 0, underflow = 0.
- RAM contents are not reset.
- Accept rules, evaluated on current registered flags:
  - write accepted = wr & ~full;
  - read accepted = rd & ~mty.
- Simultaneous accepted read and write: both take effect and count is unchanged.
  - When full, wr is rejected even if rd is asserted.
  - When empty, rd is rejected even if wr is asserted.
- Pointers advance by 1 per accepted access and wrap from DEPTH-1 to 0; no reliance on power-of-two overflow.
- count_next = count + write accepted − read accepted; never exceeds DEPTH and never goes below 0.
- Flags are registered from count_next, so they are valid in the same cycle count changes:
  - mty = (count_next == 0);
  - full = (count_next == DEPTH);
  - almost_mty = (count_next ≤ ALMOST_MTY);
  - almost_full = (count_next ≥ DEPTH-ALMOST_FULL).
- SHOW_AHEAD = 0: on an accepted read, q loads ram[rd_ptr] at that edge, so data is visible one cycle after rd. q holds otherwise, including across clr.
- SHOW_AHEAD = 1: q = ram[rd_ptr] combinationally whenever mty = 0, and q = 0 when mty = 1. An accepted rd pops the displayed word. Latency from write to q valid is 1 cycle, at the edge where mty falls.
- clr has priority over wr and rd:
  - pointers and count go to 0;
  - flags take their reset values;
  - overflow and underflow clear;
  - concurrent wr and rd are ignored and not flagged.
- ARST mid-operation discards all contents immediately; no access completes in that cycle.
- Elaboration check: DEPTH < 2 or threshold out of range causes a $fatal at elaboration.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow sets on wr & full & ~clr;
  - underflow sets on rd & mty & ~clr;
  - both are sticky until clr or ARST.
- Undefined: overflow and underflow are tied to 0 and no flag logic is synthesised. Ports remain present in both builds.

Test Plan (DATA_WIDTH=8, DEPTH=5, ALMOST_MTY=1, ALMOST_FULL=1 unless stated):
- Reset then idle → count=0, mty=1, almost_mty=1, full=0, almost_full=0, q=0.
- Write 0x11..0x15 on 5 consecutive cycles → after the 4th edge count=4 and almost_full=1; after the 5th edge full=1. A 6th wr of 0x16 is dropped, count stays 5, overflow=1 (macro on) or 0 (macro off).
- Wrap test: fill 5, read 3, write 0xA1..0xA3, read all → q sequence 0x14,0x15,0xA1,0xA2,0xA3; mty=1 after the last read; count never exceeds 5.
- Simultaneous rd & wr at count=2 for 10 cycles → count stays 2 and data order is preserved. At full, rd & wr together → read accepted, write dropped, count=4.
- SHOW_AHEAD=1: single write of 0x5A → q=0x5A in the cycle mty falls, with no rd needed. rd pops it, then q=0 and mty=1. A rd while empty sets underflow (macro on).
- clr asserted with wr=1 at count=3 and overflow set → next cycle count=0, mty=1, overflow=0, written word discarded. ARST pulse mid-stream → all outputs take reset values asynchronously.
